// File: rtl/gcn_transform_pkg.sv
// Shared types and constants for the GCN feature x weight transformation engine.
package gcn_transform_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_W,
      ST_LOAD_F,
      ST_MAC,
      ST_EMIT,
      ST_DONE
   } transform_state_t;

   localparam int DEFAULT_FEATURE_BASE = 512;

   // Wide enough that a full-length dot product of unsigned operands never overflows.
   function automatic int acc_width(input int feature_width, input int weight_width,
                                    input int weight_rows);
      return feature_width + weight_width + $clog2(weight_rows);
   endfunction

endpackage

// File: rtl/chunk_dot_unit.sv
// CHUNK-wide unsigned multiply-add tree: one partial dot product of a feature slice
// against the matching slice of a single weight column.
module chunk_dot_unit #(
   parameter int CHUNK         = 16,
   parameter int FEATURE_WIDTH = 5,
   parameter int WEIGHT_WIDTH  = 5,
   parameter int SUM_W         = FEATURE_WIDTH + WEIGHT_WIDTH + $clog2(CHUNK)
) (
   input  logic [CHUNK-1:0][FEATURE_WIDTH-1:0] feature,
   input  logic [CHUNK-1:0][WEIGHT_WIDTH-1:0]  weight,
   output logic [SUM_W-1:0]                    sum
);

   localparam int PROD_W = FEATURE_WIDTH + WEIGHT_WIDTH;

   // NOTE: blocking assignments are correct inside always_comb; the running sum is a
   // chain of combinational values, not state, and synthesis balances it into a tree.
   always_comb begin
      sum = '0;
      for (int i = 0; i < CHUNK; i++) begin
         sum = sum + SUM_W'(PROD_W'(feature[i]) * PROD_W'(weight[i]));
      end
   end

endmodule

// File: rtl/gcn_transform_engine.sv
// Feature x weight transformation engine streaming one output row per feature row.
// Define GCN_TRANSFORM_SAT_EN to saturate narrowed outputs instead of wrapping.
module gcn_transform_engine
   import gcn_transform_pkg::*;
#(
   parameter int FEATURE_ROWS   = 6,
   parameter int FEATURE_COLS   = 96,
   parameter int WEIGHT_ROWS    = 96,
   parameter int WEIGHT_COLS    = 3,
   parameter int FEATURE_WIDTH  = 5,
   parameter int WEIGHT_WIDTH   = 5,
   parameter int IN_WIDTH       = 5,
   parameter int DOT_PROD_WIDTH = 16,
   parameter int ADDRESS_WIDTH  = 13,
   parameter int FEATURE_BASE   = DEFAULT_FEATURE_BASE,
   parameter int CHUNK          = 16,
   localparam int ROW_W         = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        start,
   input  logic [WEIGHT_ROWS-1:0][IN_WIDTH-1:0]        data_in,
   output logic [ADDRESS_WIDTH-1:0]                    read_address,
   output logic                                        enable_read,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [ROW_W-1:0]                            out_row,
   output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]       out_data,
   output logic                                        busy,
   output logic                                        done
);

   localparam int ACC_W     = acc_width(FEATURE_WIDTH, WEIGHT_WIDTH, WEIGHT_ROWS);
   localparam int SUM_W     = FEATURE_WIDTH + WEIGHT_WIDTH + $clog2(CHUNK);
   localparam int COL_W     = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
   localparam int IDX_W     = (WEIGHT_ROWS > 1) ? $clog2(WEIGHT_ROWS) : 1;
   localparam int LAST_BASE = WEIGHT_ROWS - CHUNK;

   if (WEIGHT_ROWS % CHUNK != 0) begin : g_bad_chunk
      $fatal(1, "WEIGHT_ROWS must be a multiple of CHUNK");
   end
   if (FEATURE_COLS != WEIGHT_ROWS) begin : g_bad_cols
      $fatal(1, "FEATURE_COLS must equal WEIGHT_ROWS");
   end
   if (IN_WIDTH < FEATURE_WIDTH || IN_WIDTH < WEIGHT_WIDTH) begin : g_bad_in_width
      $fatal(1, "IN_WIDTH must cover both FEATURE_WIDTH and WEIGHT_WIDTH");
   end

   transform_state_t state, state_next;

   logic [COL_W-1:0] w;
   logic [ROW_W-1:0] r;
   logic [IDX_W-1:0] base;

   logic [WEIGHT_COLS-1:0][WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] wbuf;
   logic [WEIGHT_ROWS-1:0][FEATURE_WIDTH-1:0]                 fbuf;
   logic [WEIGHT_COLS-1:0][ACC_W-1:0]                         acc;

   logic [CHUNK-1:0][FEATURE_WIDTH-1:0]                       f_slice;
   logic [WEIGHT_COLS-1:0][CHUNK-1:0][WEIGHT_WIDTH-1:0]       w_slice;
   logic [WEIGHT_COLS-1:0][SUM_W-1:0]                         col_sum;

   function automatic logic [DOT_PROD_WIDTH-1:0] narrow(input logic [ACC_W-1:0] value);
`ifdef GCN_TRANSFORM_SAT_EN
      if ((value >> DOT_PROD_WIDTH) != '0) return '1;
      return DOT_PROD_WIDTH'(value);
`else
      return DOT_PROD_WIDTH'(value);
`endif
   endfunction

   always_comb begin
      f_slice = '0;
      w_slice = '0;
      for (int i = 0; i < CHUNK; i++) begin
         f_slice[i] = fbuf[base + IDX_W'(i)];
         for (int c = 0; c < WEIGHT_COLS; c++) begin
            w_slice[c][i] = wbuf[c][base + IDX_W'(i)];
         end
      end
   end

   for (genvar c = 0; c < WEIGHT_COLS; c++) begin : g_lane
      chunk_dot_unit #(
         .CHUNK        (CHUNK),
         .FEATURE_WIDTH(FEATURE_WIDTH),
         .WEIGHT_WIDTH (WEIGHT_WIDTH),
         .SUM_W        (SUM_W)
      ) u_dot (
         .feature(f_slice),
         .weight (w_slice[c]),
         .sum    (col_sum[c])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   // NOTE: every output and next-state term gets a default before the case so no
   // path through the block leaves a value unassigned and infers a latch.
   always_comb begin
      state_next   = state;
      enable_read  = 1'b0;
      read_address = '0;
      out_valid    = 1'b0;
      out_row      = '0;
      out_data     = '0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_next = ST_LOAD_W;
         end
         ST_LOAD_W: begin
            busy         = 1'b1;
            enable_read  = 1'b1;
            read_address = ADDRESS_WIDTH'(w);
            if (w == COL_W'(WEIGHT_COLS - 1)) state_next = ST_LOAD_F;
         end
         ST_LOAD_F: begin
            busy         = 1'b1;
            enable_read  = 1'b1;
            read_address = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(r);
            state_next   = ST_MAC;
         end
         ST_MAC: begin
            busy = 1'b1;
            if (base == IDX_W'(LAST_BASE)) state_next = ST_EMIT;
         end
         ST_EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_row   = r;
            for (int c = 0; c < WEIGHT_COLS; c++) begin
               out_data[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = narrow(acc[c]);
            end
            if (out_ready) begin
               state_next = (r == ROW_W'(FEATURE_ROWS - 1)) ? ST_DONE : ST_LOAD_F;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (!start) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: the operand buffers are cleared on reset along with the counters, so an
   // aborted job leaves no stale weights or features behind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w    <= '0;
         r    <= '0;
         base <= '0;
         wbuf <= '0;
         fbuf <= '0;
         acc  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  w <= '0;
                  r <= '0;
               end
            end
            ST_LOAD_W: begin
               for (int j = 0; j < WEIGHT_ROWS; j++) begin
                  wbuf[w][j] <= data_in[j][WEIGHT_WIDTH-1:0];
               end
               w <= w + 1'b1;
            end
            ST_LOAD_F: begin
               for (int j = 0; j < WEIGHT_ROWS; j++) begin
                  fbuf[j] <= data_in[j][FEATURE_WIDTH-1:0];
               end
               acc  <= '0;
               base <= '0;
            end
            ST_MAC: begin
               for (int c = 0; c < WEIGHT_COLS; c++) begin
                  acc[c] <= acc[c] + ACC_W'(col_sum[c]);
               end
               base <= base + IDX_W'(CHUNK);
            end
            ST_EMIT: begin
               if (out_ready && r != ROW_W'(FEATURE_ROWS - 1)) r <= r + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcn_transform_engine.sv
// Randomized self-checking bench for gcn_transform_engine with a memory model and a
// plain-arithmetic dot-product reference.
module tb_gcn_transform_engine;

   localparam int FR  = 6;
   localparam int FC  = 96;
   localparam int WR  = 96;
   localparam int WC  = 3;
   localparam int FW  = 5;
   localparam int WW  = 5;
   localparam int IW  = 5;
   localparam int DPW = 16;
   localparam int AW  = 13;
   localparam int FB  = 512;
   localparam int CH  = 16;
   localparam int BASE_CYCLES = WC + FR * (WR / CH + 2);

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic                   start = 1'b0;
   logic                   out_ready = 1'b0;
   logic [WR-1:0][IW-1:0]  data_in;
   logic [AW-1:0]          read_address;
   logic                   enable_read;
   logic                   out_valid;
   logic [2:0]             out_row;
   logic [WC*DPW-1:0]      out_data;
   logic                   busy;
   logic                   done;

   int wmem [WC][WR];
   int fmem [FR][WR];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gcn_transform_engine #(
      .FEATURE_ROWS  (FR),
      .FEATURE_COLS  (FC),
      .WEIGHT_ROWS   (WR),
      .WEIGHT_COLS   (WC),
      .FEATURE_WIDTH (FW),
      .WEIGHT_WIDTH  (WW),
      .IN_WIDTH      (IW),
      .DOT_PROD_WIDTH(DPW),
      .ADDRESS_WIDTH (AW),
      .FEATURE_BASE  (FB),
      .CHUNK         (CH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .data_in     (data_in),
      .read_address(read_address),
      .enable_read (enable_read),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_data    (out_data),
      .busy        (busy),
      .done        (done)
   );

   // Shared memory model: read data is valid in the same cycle as the strobe.
   always_comb begin
      data_in = '0;
      if (enable_read) begin
         if (int'(read_address) < WC) begin
            for (int j = 0; j < WR; j++) data_in[j] = IW'(wmem[int'(read_address)][j]);
         end else if (int'(read_address) >= FB && int'(read_address) < FB + FR) begin
            for (int j = 0; j < WR; j++) data_in[j] = IW'(fmem[int'(read_address) - FB][j]);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic longint expected_out(input int row, input int col);
      longint s = 0;
      for (int j = 0; j < WR; j++) s += longint'(fmem[row][j]) * longint'(wmem[col][j]);
`ifdef GCN_TRANSFORM_SAT_EN
      if (s > (longint'(1) << DPW) - 1) s = (longint'(1) << DPW) - 1;
`else
      s = s % (longint'(1) << DPW);
`endif
      return s;
   endfunction

   task automatic fill_random();
      for (int c = 0; c < WC; c++) for (int j = 0; j < WR; j++) wmem[c][j] = int'($urandom_range(0, 31));
      for (int r = 0; r < FR; r++) for (int j = 0; j < WR; j++) fmem[r][j] = int'($urandom_range(0, 31));
   endtask

   task automatic fill_const(input int wv, input int fv);
      for (int c = 0; c < WC; c++) for (int j = 0; j < WR; j++) wmem[c][j] = wv;
      for (int r = 0; r < FR; r++) for (int j = 0; j < WR; j++) fmem[r][j] = fv;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_addr"},  read_address, 0);
      check({tag, "_rd"},    enable_read, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_row"},   out_row, 0);
      check({tag, "_data"},  out_data, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
   endtask

   // Runs one job from IDLE. job_cycles counts cycles from the first LOAD_W cycle
   // until the cycle before done is first seen.
   task automatic run_job(input int stall_row, input int stall_len, input bit hold_start,
                          output int job_cycles, output logic [WC*DPW-1:0] row0_data);
      int  n = 0;
      int  rows_seen = 0;
      int  stalled = 0;
      bit  finished = 0;
      job_cycles = -1;
      row0_data  = '0;
      @(negedge clk);
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      while (!finished && n < 2000) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            if (!hold_start) start = 1'b0;
            check("first_read_en", enable_read, 1);
            check("first_read_addr", read_address, 0);
         end
         if (n == WC + 1) check("feat_read_addr", read_address, FB);
         if (done) begin
            job_cycles = n - 1;
            finished   = 1;
         end else begin
            check("busy_in_job", busy, 1);
            if (out_valid) begin
               check("out_row", out_row, rows_seen);
               for (int c = 0; c < WC; c++) begin
                  check("out_data", out_data[c*DPW +: DPW], expected_out(rows_seen, c));
               end
               if (rows_seen == 0) row0_data = out_data;
               if (rows_seen == stall_row && stalled < stall_len) begin
                  out_ready = 1'b0;
                  stalled++;
                  check("stall_no_read", enable_read, 0);
               end else begin
                  out_ready = 1'b1;
                  rows_seen++;
               end
            end
         end
      end
      if (!finished) check("job_timeout", 0, 1);
      check("rows_emitted", rows_seen, FR);
      if (hold_start) begin
         repeat (3) begin
            @(negedge clk);
            check("held_done", done, 1);
            check("held_no_restart", enable_read, 0);
            check("held_busy", busy, 0);
         end
         start = 1'b0;
      end
      @(negedge clk);
      check("back_to_idle_done", done, 0);
      check("back_to_idle_busy", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int                cyc;
      int                hs;
      int                srow;
      int                slen;
      logic [WC*DPW-1:0] row0;

      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("idle");

      // All ones: every column sums to 96.
      fill_const(1, 1);
      run_job(-1, 0, 1'b0, cyc, row0);
      check("ones_cycles", cyc, BASE_CYCLES);
      check("ones_col0", row0[DPW-1:0], 96);

      // Per-column weights c+1, feature row r all r.
      for (int c = 0; c < WC; c++) for (int j = 0; j < WR; j++) wmem[c][j] = c + 1;
      for (int r = 0; r < FR; r++) for (int j = 0; j < WR; j++) fmem[r][j] = r;
      run_job(-1, 0, 1'b0, cyc, row0);
      check("distinct_cycles", cyc, BASE_CYCLES);

      // Maximum operands overflow the output width.
      fill_const(31, 31);
      run_job(-1, 0, 1'b0, cyc, row0);
`ifdef GCN_TRANSFORM_SAT_EN
      check("overflow_col0", row0[DPW-1:0], 65535);
`else
      check("overflow_col0", row0[DPW-1:0], 26720);
`endif

      // Back-pressure on row 2 for 5 cycles.
      fill_random();
      run_job(2, 5, 1'b0, cyc, row0);
      check("stall_cycles", cyc, BASE_CYCLES + 5);

      // Reset asserted in the middle of row 3's MAC phase.
      fill_random();
      @(negedge clk);
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hs    = 0;
      for (int n = 0; n < 500 && hs < 3; n++) begin
         @(negedge clk);
         if (out_valid) hs++;
      end
      check("pre_reset_rows", hs, 3);
      repeat (3) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      #2 reset = 1'b0;
      #1 check_outputs_zero("async_reset");
      repeat (2) begin
         @(negedge clk);
         check_outputs_zero("held_reset");
      end
      reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("post_reset");
      fill_random();
      run_job(-1, 0, 1'b0, cyc, row0);
      check("rerun_cycles", cyc, BASE_CYCLES);

      // Start held high through DONE must not launch a second job.
      fill_random();
      run_job(-1, 0, 1'b1, cyc, row0);
      check("held_cycles", cyc, BASE_CYCLES);

      // Random data with random back-pressure.
      for (int t = 0; t < 3; t++) begin
         fill_random();
         srow = int'($urandom_range(0, FR - 1));
         slen = int'($urandom_range(0, 4));
         run_job(srow, slen, 1'b0, cyc, row0);
         check("random_cycles", cyc, BASE_CYCLES + slen);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gcn_transform_engine.md
# gcn_transform_engine

Parametrised feature×weight transformation engine for the GCN datapath. It loads all weight columns into a local buffer, then fetches one feature row at a time. For each row it accumulates `WEIGHT_COLS` dot products over `CHUNK`-wide slices across several cycles, and streams each finished output row on a valid/ready port. It sits between the shared feature/weight memory and the aggregation (COO) stage. The fixed-size output array is replaced by a back-pressurable stream.

## Interface
Parameters:
- `FEATURE_ROWS`, 6, number of graph nodes (feature rows).
- `FEATURE_COLS`, 96, feature row length; must equal `WEIGHT_ROWS`.
- `WEIGHT_ROWS`, 96, weight column length.
- `WEIGHT_COLS`, 3, number of output columns (lanes).
- `FEATURE_WIDTH`, 5, unsigned feature element width.
- `WEIGHT_WIDTH`, 5, unsigned weight element width.
- `IN_WIDTH`, 5, `data_in` element width; must be ≥ `FEATURE_WIDTH` and ≥ `WEIGHT_WIDTH`; low bits are used.
- `DOT_PROD_WIDTH`, 16, output element width.
- `ADDRESS_WIDTH`, 13, read address width.
- `FEATURE_BASE`, 512, address of feature row 0; weight column c is at address c.
- `CHUNK`, 16, elements multiplied per cycle; `WEIGHT_ROWS % CHUNK` must be 0, otherwise elaboration `$fatal`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: level; begins a job when sampled high in IDLE.
- `data_in` in `[WEIGHT_ROWS][IN_WIDTH]`: memory read data, valid in the same cycle as `enable_read`.
- `read_address` out `ADDRESS_WIDTH`: memory address.
- `enable_read` out 1: read strobe.
- `out_valid` out 1: output row valid.
- `out_ready` in 1: consumer accepts the row.
- `out_row` out `$clog2(FEATURE_ROWS)`: node index of `out_data`.
- `out_data` out `WEIGHT_COLS*DOT_PROD_WIDTH`: column 0 in the LSBs.
- `busy` out 1: high in any state other than IDLE or DONE.
- `done` out 1: job complete.

## Operation
- States are IDLE → LOAD_W → LOAD_F → MAC → EMIT → (LOAD_F | DONE) → IDLE.
- **IDLE:** all outputs 0. If `start` = 1, go to LOAD_W with w = 0 and r = 0.
- **LOAD_W:** drive `enable_read` = 1 and `read_address` = w. At the clock edge, capture `data_in` into `wbuf[w]`. After w = `WEIGHT_COLS`-1, go to LOAD_F.
- **LOAD_F:** drive `enable_read` = 1 and `read_address` = `FEATURE_BASE` + r. Capture the row into `fbuf`, clear all accumulators and set k = 0. Go to MAC.
- **MAC:** for each c, `acc[c] += Σ fbuf[k*CHUNK+i]*wbuf[c][k*CHUNK+i]` for i in 0..`CHUNK`-1. `enable_read` = 0. After k = `WEIGHT_ROWS/CHUNK`-1, go to EMIT.
- **EMIT:** drive `out_valid` = 1, `out_row` = r, and `out_data` = the narrowed `acc`. Hold everything stable until `out_ready` = 1. On the handshake, if r = `FEATURE_ROWS`-1 go to DONE; otherwise r++ and go to LOAD_F.
- **DONE:** `done` = 1. Stay in DONE while `start` = 1; return to IDLE when `start` = 0. This prevents a job from restarting on a held `start`.
- **Arithmetic:** all operands are unsigned.
  - Products are `FEATURE_WIDTH+WEIGHT_WIDTH` bits wide.
  - Accumulators are `FEATURE_WIDTH+WEIGHT_WIDTH+$clog2(WEIGHT_ROWS)` bits wide and never overflow internally.
  - Narrowing to `DOT_PROD_WIDTH` follows the Configuration section.
- **Boundary conditions:**
  - `start` falling mid-job is ignored.
  - `out_ready` held high in a state other than EMIT has no effect.
  - `FEATURE_ROWS` = 1 goes straight from the first EMIT to DONE.
  - Asynchronous `reset` assertion at any point forces IDLE and zeroes every register and output. A partial job is discarded, with no further reads and no `out_valid`.

## Timing
- Reset values: `read_address` = 0, `enable_read` = 0, `out_valid` = 0, `out_row` = 0, `out_data` = 0, `busy` = 0, `done` = 0.
- `start` sampled high at edge t0 gives LOAD_W from cycle t0+1. All outputs are registered or decoded from state.
- Each row takes 1 (LOAD_F) + `WEIGHT_ROWS/CHUNK` (MAC) + 1 or more (EMIT) cycles.
- With `out_ready` tied high, the job takes `WEIGHT_COLS` + `FEATURE_ROWS*(WEIGHT_ROWS/CHUNK+2)` cycles. At defaults this is 3 + 6·8 = 51 cycles, and `done` rises in cycle 52.
- Each cycle of `out_ready` back-pressure adds exactly one cycle and issues no reads.

## Configuration
- `GCN_TRANSFORM_SAT_EN` defined: any acc value > 2^`DOT_PROD_WIDTH`-1 outputs all ones.
- `GCN_TRANSFORM_SAT_EN` undefined: the output is the low `DOT_PROD_WIDTH` bits (wrap).

## Structure
- Package `gcn_transform_pkg` holds:
  - the state enum `transform_state_t`;
  - the `FEATURE_BASE` default constant;
  - the accumulator-width helper function.
- Sub-module `chunk_dot_unit`: `CHUNK`-wide multiply-add tree for one weight column. It is instantiated `WEIGHT_COLS` times.

## Test plan
- **Defaults, simple data:** features all 1, weights all 1, `out_ready` = 1 → 6 rows, each `out_data` column = 96. Rows appear with `out_row` 0..5 in order. `done` rises 51 cycles after LOAD_W begins.
- **Distinct per-column weights:** weight column c all (c+1), feature row r all r → row r outputs {96r, 192r, 288r}, checked against a golden model.
- **Overflow:** all operands 31 → 92256 per column. Without the macro the output is 26720; with `GCN_TRANSFORM_SAT_EN` it is 65535.
- **Back-pressure:** `out_ready` low for 5 cycles on row 2 → `out_data` and `out_row` stay stable, `enable_read` stays 0, and `done` is delayed by exactly 5 cycles.
- **Reset mid-MAC** (row 3): all outputs are 0 next cycle. A new `start` reruns from weight column 0 with correct results.
- **Held `start`:** `start` held high through DONE → no second job; IDLE is entered after `start` drops.
